// File: rtl/control_jugada.sv
// Move-entry controller for a 3x3 board.
// Two raw buttons are synchronized and debounced into single-cycle presses.
// A small FSM moves a cursor over free cells and hands each accepted move
// to the move register through a valid/ack handshake.
//
// state  | meaning
// SELECT | cursor editable; waits for next/confirm or game over
// SEND   | move word presented on registro2, escribir high until ack
// LOCK   | game over; everything frozen until reset_n
module control_jugada #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_next,
  input  logic       btn_confirm,
  input  logic [8:0] ocupado,
  input  logic       juego_fin,
  input  logic       ack,
  output logic [3:0] cursor,
  output logic [1:0] jugador,
  output logic [5:0] registro2,
  output logic       escribir,
  output logic       error_ocupado
);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    SEND   = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int CW = $clog2(DEB_CYCLES + 2);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DEB_CYCLES - 1);
  // The two synchronizer stages hold their cleared value for two samples after
  // reset; starting the run counter two higher keeps those fake zeros from
  // counting as a confirmed release.
  localparam logic [CW-1:0] CNT_START = CW'(DEB_CYCLES + 1);

  // index 0 = next, index 1 = confirm
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, smp, deb, armed, press;
  logic [CW-1:0] cnt      [2];
  logic [CW-1:0] cnt_next [2];

  state_t     state, state_d;
  logic [3:0] cursor_d;
  logic [1:0] jugador_d;
  logic [5:0] registro2_d;
  logic       error_d;

  assign raw = {btn_confirm, btn_next};

  // Run-length counter per button; press fires on an accepted rising level,
  // but only once a released level has been confirmed since reset.
  always_comb begin
    cnt_next = '{default: '0};
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] != smp[i])
        cnt_next[i] = CNT_RELOAD;
      else if (cnt[i] == '0)
        cnt_next[i] = '0;
      else
        cnt_next[i] = cnt[i] - 1'b1;
      press[i] = armed[i] & ~deb[i] & sync2[i] & (cnt_next[i] == '0);
    end
  end

  // Synchronizers, debouncer state and release-arming flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      smp   <= '0;
      deb   <= '0;
      armed <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= CNT_START;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      smp   <= sync2;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt_next[i];
        if (cnt_next[i] == '0) begin
          deb[i] <= sync2[i];
          if (!sync2[i]) armed[i] <= 1'b1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SELECT;
      cursor        <= 4'd0;
      jugador       <= 2'b01;
      registro2     <= 6'b000000;
      error_ocupado <= 1'b0;
    end else begin
      state         <= state_d;
      cursor        <= cursor_d;
      jugador       <= jugador_d;
      registro2     <= registro2_d;
      error_ocupado <= error_d;
    end
  end

  // Next-state decode; game over wins over any button in SELECT.
  always_comb begin
    state_d = state;
    case (state)
      SELECT: begin
        if (juego_fin)
          state_d = LOCK;
        else if (press[1] && !ocupado[cursor])
          state_d = SEND;
      end
      SEND:    if (ack) state_d = SELECT;
      LOCK:    state_d = LOCK;
      default: state_d = SELECT;
    endcase
  end

  // Datapath next values; confirm beats next, presses outside SELECT are dropped.
  always_comb begin
    cursor_d    = cursor;
    jugador_d   = jugador;
    registro2_d = registro2;
    error_d     = 1'b0;
    case (state)
      SELECT: begin
        if (!juego_fin) begin
          if (press[1]) begin
            if (ocupado[cursor])
              error_d = 1'b1;
            else
              registro2_d = {jugador, cursor};
          end else if (press[0]) begin
            cursor_d = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
          end
        end
      end
      SEND:    if (ack) jugador_d = ~jugador;
      default: ;
    endcase
  end

  // Decoded from the state register so reset drops it immediately.
  assign escribir = (state == SEND);

endmodule

// File: tb/tb_control_jugada.sv
// Directed bench for control_jugada with hand-computed expectations.
module tb_control_jugada;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_confirm = 1'b0;
  logic [8:0] ocupado = 9'd0;
  logic       juego_fin = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] cursor;
  logic [1:0] jugador;
  logic [5:0] registro2;
  logic       escribir;
  logic       error_ocupado;

  int checks = 0;
  int errors = 0;
  int ec;
  int wc;

  always #5 clk = ~clk;

  control_jugada #(.DEB_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_next      (btn_next),
    .btn_confirm   (btn_confirm),
    .ocupado       (ocupado),
    .juego_fin     (juego_fin),
    .ack           (ack),
    .cursor        (cursor),
    .jugador       (jugador),
    .registro2     (registro2),
    .escribir      (escribir),
    .error_ocupado (error_ocupado)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
  endtask

  task automatic press(input logic nxt, input logic conf);
    btn_next    = nxt;
    btn_confirm = conf;
    cyc(8);
    btn_next    = 1'b0;
    btn_confirm = 1'b0;
    cyc(8);
  endtask

  task automatic do_ack;
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    // reset values
    cyc(3);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_jugador", int'(jugador), 1);
    chk("rst_registro2", int'(registro2), 0);
    chk("rst_escribir", int'(escribir), 0);
    chk("rst_error", int'(error_ocupado), 0);
    reset_n = 1'b1;
    cyc(10);

    // three nexts then confirm, with latency from raw press: 2 sync + 4 debounce
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    chk("cursor_after_3", int'(cursor), 3);
    btn_confirm = 1'b1;
    cyc(5);
    chk("lat_before", int'(escribir), 0);
    cyc(1);
    chk("lat_at", int'(escribir), 1);
    cyc(2);
    btn_confirm = 1'b0;
    cyc(8);
    chk("move_word", int'(registro2), 6'b010011);
    chk("move_escribir", int'(escribir), 1);
    do_ack;
    chk("ack_escribir", int'(escribir), 0);
    chk("ack_jugador", int'(jugador), 2);
    chk("ack_word_kept", int'(registro2), 6'b010011);

    // ten nexts with wrap 8 -> 0
    do_reset;
    for (int i = 0; i < 10; i++) begin
      press(1'b1, 1'b0);
      chk("next_seq", int'(cursor), (i + 1) % 9);
    end

    // confirm on occupied cell
    do_reset;
    ocupado = 9'b000000001;
    ec = 0;
    wc = 0;
    btn_confirm = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (error_ocupado) ec++;
      if (escribir) wc++;
      if (k == 7) btn_confirm = 1'b0;
    end
    chk("err_pulse_len", ec, 1);
    chk("err_no_write", wc, 0);
    chk("err_cursor", int'(cursor), 0);
    chk("err_word", int'(registro2), 0);
    press(1'b1, 1'b0);
    chk("err_still_select", int'(cursor), 1);
    ocupado = 9'd0;

    // simultaneous confirm and next: move uses pre-increment cursor
    do_reset;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("both_word", int'(registro2), 6'b010010);
    chk("both_cursor", int'(cursor), 2);
    chk("both_escribir", int'(escribir), 1);
    do_ack;
    chk("both_cursor_after", int'(cursor), 2);

    // SEND holds while buttons toggle and ack stays low
    do_reset;
    press(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      btn_next    = ((k / 5) % 2) == 1;
      btn_confirm = (((k + 2) / 5) % 2) == 1;
      cyc(1);
      chk("hold_escribir", int'(escribir), 1);
      chk("hold_word", int'(registro2), 6'b010000);
      chk("hold_cursor", int'(cursor), 0);
    end
    btn_next    = 1'b0;
    btn_confirm = 1'b0;
    cyc(10);
    chk("hold_still_send", int'(escribir), 1);
    do_ack;
    chk("hold_release", int'(escribir), 0);
    chk("hold_jugador", int'(jugador), 2);
    cyc(12);
    chk("hold_not_queued", int'(cursor), 0);
    chk("hold_no_rewrite", int'(escribir), 0);

    // game over during SEND completes the transfer, then LOCK
    do_reset;
    press(1'b0, 1'b1);
    juego_fin = 1'b1;
    cyc(3);
    chk("fin_send_kept", int'(escribir), 1);
    do_ack;
    chk("fin_ack_escribir", int'(escribir), 0);
    chk("fin_ack_jugador", int'(jugador), 2);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    do_ack;
    juego_fin = 1'b0;
    press(1'b1, 1'b0);
    chk("lock_cursor", int'(cursor), 0);
    chk("lock_escribir", int'(escribir), 0);
    chk("lock_word", int'(registro2), 6'b010000);
    chk("lock_jugador", int'(jugador), 2);
    do_reset;
    chk("unlock_jugador", int'(jugador), 1);
    chk("unlock_word", int'(registro2), 0);
    press(1'b1, 1'b0);
    chk("unlock_cursor", int'(cursor), 1);

    // short glitch on confirm is not a press
    do_reset;
    wc = 0;
    btn_confirm = 1'b1;
    cyc(3);
    btn_confirm = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (escribir) wc++;
    end
    chk("glitch_no_write", wc, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("pre_rst_word", int'(registro2), 6'b010001);
    chk("pre_rst_escribir", int'(escribir), 1);

    // asynchronous reset in SEND
    cyc(2);
    reset_n = 1'b0;
    #1;
    chk("async_escribir", int'(escribir), 0);
    chk("async_jugador", int'(jugador), 1);
    chk("async_word", int'(registro2), 0);
    chk("async_cursor", int'(cursor), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(10);

    // button held through reset release gives no press until re-pressed
    btn_next = 1'b1;
    do_reset;
    cyc(10);
    chk("held_no_press", int'(cursor), 0);
    btn_next = 1'b0;
    cyc(8);
    press(1'b1, 1'b0);
    chk("held_repress", int'(cursor), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_jugada.md
CONTROL_JUGADA -- requirements
Module: control_jugada

Interface
REQ-001 Parameter DEB_CYCLES, default 4: clock cycles a synchronized button level must stay stable before it is accepted.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn_next  input  1  raw button; each accepted press advances the cursor.
REQ-005 btn_confirm  input  1  raw button; an accepted press requests a move at the cursor cell.
REQ-006 ocupado  input  9  bit i high = board cell i already taken.
REQ-007 juego_fin  input  1  level, high = game over (win or draw).
REQ-008 ack  input  1  level from the register side: word accepted this cycle.
REQ-009 cursor  output  4  selected cell index, 0..8.
REQ-010 jugador  output  2  player to move: 01 = X, 10 = O.
REQ-011 registro2  output  6  move word {jugador[1:0], cell[3:0]}; feeds the 6-bit move register.
REQ-012 escribir  output  1  write-valid strobe for registro2.
REQ-013 error_ocupado  output  1  one-cycle pulse flagging a rejected confirm.

Function
REQ-014 Each button shall pass a 2-flop synchronizer, then a debouncer that updates its stable level only after DEB_CYCLES consecutive equal samples.
REQ-015 An accepted press shall be a single-cycle pulse on the 0->1 transition of the debounced level; holding a button shall generate no further pulses.
REQ-016 The FSM shall have exactly the states SELECT, SEND and LOCK.
REQ-017 SELECT, next pulse: cursor shall increment by 1 and wrap from 8 to 0; values 9..15 shall never appear.
REQ-018 SELECT, confirm pulse with ocupado[cursor]=1: error_ocupado shall be high for exactly the next cycle; the FSM stays in SELECT; no other output changes.
REQ-019 SELECT, confirm pulse with ocupado[cursor]=0: on the next edge registro2 <= {jugador, cursor}, escribir <= 1, state <= SEND.
REQ-020 SEND: escribir and registro2 shall hold steady until ack is sampled high.
REQ-021 SEND, ack=1: on that edge escribir <= 0, jugador toggles (01<->10), state <= SELECT; registro2 keeps its last value.
REQ-022 ack while not in SEND shall be ignored.
REQ-023 next and confirm pulses outside SELECT shall be discarded, not queued.
REQ-024 SELECT, confirm and next pulses in the same cycle: confirm takes priority; the move uses the pre-increment cursor; next is discarded.
REQ-025 juego_fin=1 in SELECT shall move the FSM to LOCK on the next edge, taking priority over any same-cycle button pulse.
REQ-026 juego_fin=1 in SEND shall not abort the transfer; after ack the FSM enters SELECT, then LOCK on the following edge.
REQ-027 LOCK shall hold all outputs static with escribir=0; only reset_n leaves LOCK.
REQ-028 Latency: confirm pulse to escribir high = 1 cycle; ack to escribir low = 1 cycle.

Reset
REQ-029 reset_n low shall immediately force: state SELECT, cursor 0, jugador 01, registro2 000000, escribir 0, error_ocupado 0, synchronizers and debouncers cleared to 0.
REQ-030 Reset asserted during SEND shall drop escribir at once without waiting for ack; the move is lost.
REQ-031 After reset_n rises, a button already held high shall not produce a press until it is released and pressed again.

Verification
REQ-032 Reset, ocupado=0, btn_next pressed 3 times, then btn_confirm -> cursor=3, escribir=1, registro2=010011; ack 1 cycle -> escribir=0, jugador=10.
REQ-033 btn_next pressed 10 times from cursor 0 -> cursor sequence 1..8,0,1; final cursor=1.
REQ-034 ocupado=9'b000000001, cursor=0, btn_confirm -> error_ocupado single-cycle pulse; escribir stays 0; state stays SELECT.
REQ-035 In SEND, ack held 0 for 20 cycles while both buttons toggle -> registro2 and escribir stable and cursor unchanged; ack=1 -> release in 1 cycle.
REQ-036 juego_fin=1 asserted during SEND -> transfer completes on ack, then LOCK; further presses -> no output change until reset_n.
REQ-037 btn_confirm glitch shorter than DEB_CYCLES -> no press; reset_n low mid-SEND -> escribir=0 immediately and jugador=01.
